// File: rtl/lift_ctrl_n_if.sv
// Request/status bundle between the hall-call queue, the lift controller and
// the motor/indicator logic.
interface lift_ctrl_n_if #(
    parameter int FLOOR_W = 3
);
    logic               req_valid;
    logic               req_ready;
    logic [FLOOR_W-1:0] req_floor;
    logic               req_dir;
    logic [FLOOR_W-1:0] cur_floor;
    logic [1:0]         dout;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output req_valid, req_floor, req_dir,
        input  req_ready, cur_floor, dout, busy, done, err
    );

    modport slave (
        input  req_valid, req_floor, req_dir,
        output req_ready, cur_floor, dout, busy, done, err
    );
endinterface

// File: rtl/lift_ctrl_n.sv
// N-floor elevator controller: takes one hall call, drives the car to the
// pickup floor, then carries it one floor in the requested direction.
module lift_ctrl_n #(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = 3,
    parameter int TRAVEL_CYC = 4,
    parameter int DOOR_CYC   = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    lift_ctrl_n_if.slave bus
);
    localparam int MAX_CYC = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0]   T_LAST   = CNT_W'(TRAVEL_CYC - 1);
    localparam logic [CNT_W-1:0]   D_LAST   = CNT_W'(DOOR_CYC - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [FLOOR_W:0]   NF       = (FLOOR_W + 1)'(NUM_FLOORS);
    localparam logic [FLOOR_W-1:0] TOP      = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W-1:0] FL_ONE   = FLOOR_W'(1);
    localparam logic [1:0]         DIR_UP   = 2'b00;
    localparam logic [1:0]         DIR_DOWN = 2'b01;
    localparam logic [1:0]         DIR_STAY = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        MOVE_PICK,
        DOOR_PICK,
        MOVE_DEST,
        DOOR_DEST
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   tcnt, tcnt_nxt;
    logic [CNT_W-1:0]   dcnt, dcnt_nxt;
    logic [FLOOR_W-1:0] floor_r, floor_nxt, step_floor;
    logic [FLOOR_W-1:0] pick_r, dest_r;
    logic               dir_r;
    logic               done_r, done_nxt;
    logic               err_r, err_nxt;
    logic               accept;
    logic               illegal;

    assign accept = bus.req_valid && (state == IDLE);

    // Any request that would push the car past either end is consumed but dropped.
    assign illegal = ({1'b0, bus.req_floor} >= NF)
                  || (!bus.req_dir && (bus.req_floor == TOP))
                  || ( bus.req_dir && (bus.req_floor == '0));

    assign step_floor = (pick_r > floor_r) ? (floor_r + FL_ONE) : (floor_r - FL_ONE);

    always_comb begin
        state_nxt     = state;
        tcnt_nxt      = tcnt;
        dcnt_nxt      = dcnt;
        floor_nxt     = floor_r;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        bus.dout      = DIR_STAY;
        bus.busy      = 1'b1;
        bus.req_ready = 1'b0;
        case (state)
            IDLE: begin
                bus.busy      = 1'b0;
                bus.req_ready = 1'b1;
                if (accept) begin
                    if (illegal)
                        err_nxt = 1'b1;
                    else if (bus.req_floor == floor_r)
                        state_nxt = DOOR_PICK;
                    else
                        state_nxt = MOVE_PICK;
                end
            end
            MOVE_PICK: begin
                bus.dout = (pick_r > floor_r) ? DIR_UP : DIR_DOWN;
                if (tcnt == T_LAST) begin
                    tcnt_nxt  = '0;
                    floor_nxt = step_floor;
                    if (step_floor == pick_r)
                        state_nxt = DOOR_PICK;
                end else begin
                    tcnt_nxt = tcnt + CNT_ONE;
                end
            end
            DOOR_PICK: begin
                if (dcnt == D_LAST) begin
                    dcnt_nxt  = '0;
                    state_nxt = MOVE_DEST;
                end else begin
                    dcnt_nxt = dcnt + CNT_ONE;
                end
            end
            MOVE_DEST: begin
                bus.dout = dir_r ? DIR_DOWN : DIR_UP;
                if (tcnt == T_LAST) begin
                    tcnt_nxt  = '0;
                    floor_nxt = dest_r;
                    state_nxt = DOOR_DEST;
                end else begin
                    tcnt_nxt = tcnt + CNT_ONE;
                end
            end
            DOOR_DEST: begin
                if (dcnt == D_LAST) begin
                    dcnt_nxt  = '0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    dcnt_nxt = dcnt + CNT_ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            tcnt    <= '0;
            dcnt    <= '0;
            floor_r <= '0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state   <= state_nxt;
            tcnt    <= tcnt_nxt;
            dcnt    <= dcnt_nxt;
            floor_r <= floor_nxt;
            done_r  <= done_nxt;
            err_r   <= err_nxt;
        end
    end

    // Trip data is only consulted outside IDLE, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            pick_r <= bus.req_floor;
            dir_r  <= bus.req_dir;
            dest_r <= bus.req_dir ? (bus.req_floor - FL_ONE) : (bus.req_floor + FL_ONE);
        end
    end

    assign bus.cur_floor = floor_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
endmodule
